debug_tx_dumper: RTL and testbench
==================================

Name: debug_tx_dumper

Overview:
- Transmit-side companion of the MIPS debug unit: on a dump request (halt in continuous mode, or after each step in step-by-step mode), serializes a CPU state snapshot into UART TX bytes.
- Frame layout, in order:
  - sync byte
  - PC
  - cycle counter
  - register file contents
  - data memory window
- Drives the UART transmitter through the tx_start / tx_done_tick handshake.
- Reads the register file and data memory through synchronous read ports.

Parameters:
- NBIT_DATA_LEN, 8: UART byte width.
- LEN_DATA, 32: CPU word width; each word is sent as LEN_DATA/NBIT_DATA_LEN bytes.
- NREGS, 32: number of registers dumped, addresses 0..NREGS-1.
- NBIT_REG, 5: register address width.
- NMEM, 16: number of data memory words dumped, word addresses 0..NMEM-1.
- NBIT_MEM, 4: memory address width.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dump_req  in  1  single-cycle pulse; starts a frame when idle
- pc_in  in  LEN_DATA  PC, captured on an accepted dump_req
- cycles_in  in  LEN_DATA  cycle counter, captured on an accepted dump_req
- reg_addr  out  NBIT_REG  register file read address
- reg_data  in  LEN_DATA  register file read data, valid 1 cycle after reg_addr
- mem_addr  out  NBIT_MEM  data memory read address
- mem_data  in  LEN_DATA  data memory read data, valid 1 cycle after mem_addr
- tx_start  out  1  one-cycle pulse; tx_data is valid
- tx_data  out  NBIT_DATA_LEN  byte to transmit
- tx_done_tick  in  1  one-cycle pulse from UART at end of a byte
- busy  out  1  high while a frame is in progress
- dump_done  out  1  one-cycle pulse after the last byte's tx_done_tick

Behaviour:
- Reset values of all outputs:
  - tx_start=0, tx_data=0, busy=0, dump_done=0, reg_addr=0, mem_addr=0.
  - Internal state returns to IDLE.
- FSM states: IDLE, FETCH, LATCH, SEND, WAIT_DONE, NEXT.
- IDLE:
  - dump_req=1 → snapshot pc_in and cycles_in, set busy=1, load the shift register with SYNC_BYTE as a 1-byte word, go to SEND.
- SEND:
  - Drive tx_data = shift[7:0] and tx_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - Hold tx_data stable.
  - On tx_done_tick: shift right by 8 and decrement the byte counter.
  - If bytes remain in the current word → SEND; otherwise → NEXT.
- NEXT: select the next word source.
  - Order: PC, cycles, reg 0..NREGS-1, mem 0..NMEM-1.
  - PC and cycles load directly from the snapshot and go to SEND.
  - A reg or mem word drives the address and goes to FETCH.
  - After the last mem word → IDLE, pulsing dump_done=1 and setting busy=0 on the same edge.
- FETCH: wait one cycle for read latency.
- LATCH: capture reg_data or mem_data into the shift register, byte counter=4, then go to SEND.
- Byte order is LSB first within each word.
- Frame length = 1 + 4*(2+NREGS+NMEM) bytes; 201 with the default parameters.
- Byte-to-byte gap: tx_start for the next byte occurs no earlier than 2 cycles after tx_done_tick.
- dump_req while busy: ignored, with no queuing.
- tx_done_tick outside WAIT_DONE: ignored.
- Reset mid-frame: abort to IDLE on that edge with tx_start=0. The byte already in flight in the UART is not tracked.
- Word and address counters never wrap mid-frame. The frame terminates exactly after index NREGS-1 for registers and NMEM-1 for memory.
- pc_in and cycles_in changing after capture have no effect on the frame.

Optional Feature:
- DEBUG_TX_CHECKSUM_EN defined:
  - Keep a running XOR of every byte sent after SYNC_BYTE.
  - After the last mem byte, send the XOR as one extra byte, then assert dump_done.
  - Frame length is 202 with the default parameters.
- Undefined: no checksum byte, no XOR register.

Decomposition:
- Shared package holds:
  - FSM state encodings.
  - Word source select encodings: SRC_SYNC, SRC_PC, SRC_CYC, SRC_REG, SRC_MEM, SRC_CSUM.
  - SYNC_BYTE.
  - Command byte constants shared with the receive side: StartSignal=8'h01, ContinuousSignal=8'h02, StepByStepSignal=8'h03, ReProgramSignal=8'h05, StepSignal=8'h06.
- One natural sub-module: word_byte_serializer. It loads a word and byte count, emits bytes LSB first, and handshakes with tx_start/tx_done_tick. It is reused by the top FSM for every source.

Test Plan:
- PC=0x00400010, cycles=0x0000002A, regs[i]=i, mem[j]=0x100+j, with a UART model asserting tx_done_tick 10 cycles after tx_start → bytes start A5,10,00,40,00,2A,00,00,00,00,00,00,00,01,00,00,00. Total 201 bytes, then one dump_done pulse and busy=0.
- Read latency: reg_data is X except exactly 1 cycle after reg_addr → no X appears in tx_data, and reg_addr steps 0..31 in order.
- dump_req re-pulsed at byte 50 → ignored, still exactly 201 bytes and one dump_done.
- reset asserted while waiting on byte 100 → next cycle busy=0, tx_start=0. A new dump_req then restarts from A5.
- Spurious tx_done_tick while IDLE, or during FETCH → no byte skipped or duplicated.
- With DEBUG_TX_CHECKSUM_EN defined, regs and mem all zero, PC=0x01020304, cycles=0 → last byte 0x04 (1^2^3^4), 202 bytes total.

Source files
------------

// File: rtl/debug_tx_dumper_pkg.sv
// Shared definitions for the debug unit TX dumper: FSM and word-source encodings,
// frame constants, command bytes shared with the receive side, and the checksum helper.
package debug_tx_dumper_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  // Command bytes understood by the receive side of the debug unit
  localparam logic [BYTE_W-1:0] StartSignal      = 8'h01;
  localparam logic [BYTE_W-1:0] ContinuousSignal = 8'h02;
  localparam logic [BYTE_W-1:0] StepByStepSignal = 8'h03;
  localparam logic [BYTE_W-1:0] ReProgramSignal  = 8'h05;
  localparam logic [BYTE_W-1:0] StepSignal       = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SRC_SYNC = 3'd0,
    SRC_PC   = 3'd1,
    SRC_CYC  = 3'd2,
    SRC_REG  = 3'd3,
    SRC_MEM  = 3'd4,
    SRC_CSUM = 3'd5
  } src_e;

  function automatic logic [BYTE_W-1:0] csum_update(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] data_byte);
    return acc ^ data_byte;
  endfunction

endpackage

// File: rtl/debug_tx_dumper_if.sv
// Bundle of the dumper's request, snapshot, register/memory read and UART TX signals.
// master = the dumper, slave = the surrounding debug unit / UART / storage.
interface debug_tx_dumper_if #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int LEN_DATA      = 32,
  parameter int NBIT_REG      = 5,
  parameter int NBIT_MEM      = 4
);
  logic                     dump_req;
  logic [LEN_DATA-1:0]      pc_in;
  logic [LEN_DATA-1:0]      cycles_in;
  logic [NBIT_REG-1:0]      reg_addr;
  logic [LEN_DATA-1:0]      reg_data;
  logic [NBIT_MEM-1:0]      mem_addr;
  logic [LEN_DATA-1:0]      mem_data;
  logic                     tx_start;
  logic [NBIT_DATA_LEN-1:0] tx_data;
  logic                     tx_done_tick;
  logic                     busy;
  logic                     dump_done;

  modport master (
    input  dump_req, pc_in, cycles_in, reg_data, mem_data, tx_done_tick,
    output reg_addr, mem_addr, tx_start, tx_data, busy, dump_done
  );

  modport slave (
    output dump_req, pc_in, cycles_in, reg_data, mem_data, tx_done_tick,
    input  reg_addr, mem_addr, tx_start, tx_data, busy, dump_done
  );
endinterface

// File: rtl/debug_tx_dumper_word_byte_serializer.sv
// word_byte_serializer: holds one word and emits it LSB byte first, one tx_start
// pulse per byte, consuming tx_done_tick only while the sequencer is waiting.
module word_byte_serializer #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int LEN_DATA      = 32,
  parameter int CNT_W         = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [LEN_DATA-1:0]      load_word,
  input  logic [CNT_W-1:0]         load_nbytes,
  input  logic                     send,
  input  logic                     wait_en,
  input  logic                     tx_done_tick,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data,
  output logic                     accept,
  output logic                     last_byte
);

  localparam logic [CNT_W-1:0] ONE_BYTE = CNT_W'(1);

  logic [LEN_DATA-1:0]      shift_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     tx_start_r;
  logic [NBIT_DATA_LEN-1:0] tx_data_r;

  assign accept    = wait_en & tx_done_tick;
  assign last_byte = (cnt_r == ONE_BYTE);
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;

  // Word shift register and remaining-byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      shift_r <= load_word;
      cnt_r   <= load_nbytes;
    end else if (accept) begin
      shift_r <= shift_r >> NBIT_DATA_LEN;
      cnt_r   <= cnt_r - ONE_BYTE;
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // tx_data is latched at send and held for the whole UART byte time
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
    end else begin
      tx_start_r <= send;
      if (send) begin
        tx_data_r <= shift_r[NBIT_DATA_LEN-1:0];
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

endmodule

// File: rtl/debug_tx_dumper.sv
// debug_tx_dumper: on dump_req, sends sync, PC, cycles, register file and data memory window
// over UART. Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte after the memory window.
module debug_tx_dumper
  import debug_tx_dumper_pkg::*;
#(
  parameter int NBIT_DATA_LEN = 8,
  parameter int LEN_DATA      = 32,
  parameter int NREGS         = 32,
  parameter int NBIT_REG      = 5,
  parameter int NMEM          = 16,
  parameter int NBIT_MEM      = 4
) (
  input logic               clk,
  input logic               reset,
  debug_tx_dumper_if.master bus
);

  localparam int BYTES_PER_WORD = LEN_DATA / NBIT_DATA_LEN;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CNT_W-1:0]    WORD_BYTES = CNT_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]    ONE_BYTE   = CNT_W'(1);
  localparam logic [NBIT_REG-1:0] LAST_REG   = NBIT_REG'(NREGS - 1);
  localparam logic [NBIT_MEM-1:0] LAST_MEM   = NBIT_MEM'(NMEM - 1);

  state_e                   state_r, state_s;
  src_e                     src_r, src_s;
  logic [NBIT_REG-1:0]      reg_addr_r, reg_addr_s;
  logic [NBIT_MEM-1:0]      mem_addr_r, mem_addr_s;
  logic                     busy_r;
  logic                     dump_done_r;
  logic [LEN_DATA-1:0]      snap_pc_r;
  logic [LEN_DATA-1:0]      snap_cyc_r;
  logic                     snap_s;
  logic                     finish_s;
  logic                     ser_load_s;
  logic [LEN_DATA-1:0]      ser_word_s;
  logic [CNT_W-1:0]         ser_nbytes_s;
  logic                     ser_send_s;
  logic                     ser_wait_s;
  logic                     ser_accept_s;
  logic                     ser_last_s;
  logic                     ser_tx_start_s;
  logic [NBIT_DATA_LEN-1:0] ser_tx_data_s;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [BYTE_W-1:0]        csum_r;
`endif

  assign ser_wait_s    = (state_r == ST_WAIT_DONE);
  assign bus.tx_start  = ser_tx_start_s;
  assign bus.tx_data   = ser_tx_data_s;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.busy      = busy_r;
  assign bus.dump_done = dump_done_r;

  word_byte_serializer #(
    .NBIT_DATA_LEN(NBIT_DATA_LEN),
    .LEN_DATA     (LEN_DATA),
    .CNT_W        (CNT_W)
  ) u_ser (
    .clk         (clk),
    .reset       (reset),
    .load        (ser_load_s),
    .load_word   (ser_word_s),
    .load_nbytes (ser_nbytes_s),
    .send        (ser_send_s),
    .wait_en     (ser_wait_s),
    .tx_done_tick(bus.tx_done_tick),
    .tx_start    (ser_tx_start_s),
    .tx_data     (ser_tx_data_s),
    .accept      (ser_accept_s),
    .last_byte   (ser_last_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, word-source sequencing and serializer control
  always_comb begin
    state_s      = state_r;
    src_s        = src_r;
    reg_addr_s   = reg_addr_r;
    mem_addr_s   = mem_addr_r;
    snap_s       = 1'b0;
    finish_s     = 1'b0;
    ser_load_s   = 1'b0;
    ser_word_s   = '0;
    ser_nbytes_s = '0;
    ser_send_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.dump_req) begin
          snap_s       = 1'b1;
          ser_load_s   = 1'b1;
          ser_word_s   = LEN_DATA'(SYNC_BYTE);
          ser_nbytes_s = ONE_BYTE;
          src_s        = SRC_SYNC;
          state_s      = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        ser_send_s = 1'b1;
        state_s    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (ser_accept_s) begin
          if (ser_last_s) begin
            state_s = ST_NEXT;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_NEXT: begin
        // Snapshot words go straight out; storage words need an address and a read cycle
        case (src_r)
          SRC_SYNC: begin
            ser_load_s   = 1'b1;
            ser_word_s   = snap_pc_r;
            ser_nbytes_s = WORD_BYTES;
            src_s        = SRC_PC;
            state_s      = ST_SEND;
          end
          SRC_PC: begin
            ser_load_s   = 1'b1;
            ser_word_s   = snap_cyc_r;
            ser_nbytes_s = WORD_BYTES;
            src_s        = SRC_CYC;
            state_s      = ST_SEND;
          end
          SRC_CYC: begin
            src_s      = SRC_REG;
            reg_addr_s = '0;
            state_s    = ST_FETCH;
          end
          SRC_REG: begin
            if (reg_addr_r == LAST_REG) begin
              src_s      = SRC_MEM;
              mem_addr_s = '0;
            end else begin
              reg_addr_s = reg_addr_r + NBIT_REG'(1);
            end
            state_s = ST_FETCH;
          end
          SRC_MEM: begin
            if (mem_addr_r == LAST_MEM) begin
`ifdef DEBUG_TX_CHECKSUM_EN
              ser_load_s   = 1'b1;
              ser_word_s   = LEN_DATA'(csum_r);
              ser_nbytes_s = ONE_BYTE;
              src_s        = SRC_CSUM;
              state_s      = ST_SEND;
`else
              finish_s = 1'b1;
              state_s  = ST_IDLE;
`endif
            end else begin
              mem_addr_s = mem_addr_r + NBIT_MEM'(1);
              state_s    = ST_FETCH;
            end
          end
          SRC_CSUM: begin
            finish_s = 1'b1;
            state_s  = ST_IDLE;
          end
          default: begin
            finish_s = 1'b1;
            state_s  = ST_IDLE;
          end
        endcase
      end
      ST_FETCH: begin
        state_s = ST_LATCH;
      end
      ST_LATCH: begin
        ser_load_s   = 1'b1;
        ser_nbytes_s = WORD_BYTES;
        state_s      = ST_SEND;
        if (src_r == SRC_MEM) begin
          ser_word_s = bus.mem_data;
        end else begin
          ser_word_s = bus.reg_data;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Source pointer, read addresses, snapshot and frame status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r       <= SRC_SYNC;
      reg_addr_r  <= '0;
      mem_addr_r  <= '0;
      busy_r      <= 1'b0;
      dump_done_r <= 1'b0;
      snap_pc_r   <= '0;
      snap_cyc_r  <= '0;
    end else begin
      src_r       <= src_s;
      reg_addr_r  <= reg_addr_s;
      mem_addr_r  <= mem_addr_s;
      dump_done_r <= finish_s;
      if (snap_s) begin
        snap_pc_r  <= bus.pc_in;
        snap_cyc_r <= bus.cycles_in;
        busy_r     <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

`ifdef DEBUG_TX_CHECKSUM_EN
  // Running XOR of every completed byte after the sync byte
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_r <= '0;
    end else if (snap_s) begin
      csum_r <= '0;
    end else if (ser_accept_s && (src_r != SRC_SYNC) && (src_r != SRC_CSUM)) begin
      csum_r <= csum_update(csum_r, ser_tx_data_s);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

endmodule

// File: tb/tb_debug_tx_dumper.sv
// Scoreboard bench for debug_tx_dumper: frames are predicted from the bench's own register/memory
// images into a byte queue; a monitor pops and compares on every tx_start.
module tb_debug_tx_dumper;

`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int         FRAME_LEN = 202;
  localparam logic [7:0] LAST_EXP  = 8'h04;
`else
  localparam int         FRAME_LEN = 201;
  localparam logic [7:0] LAST_EXP  = 8'h00;
`endif
  // Stands in for undefined read data in the cycle an address is first presented
  localparam logic [31:0] POISON = 32'hBAAD_F00D;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debug_tx_dumper_if bus ();
  debug_tx_dumper dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] regs [32];
  logic [31:0] mems [16];
  logic [31:0] reg_q, mem_q;
  logic [4:0]  reg_addr_q;
  logic [3:0]  mem_addr_q;
  logic        uart_tick  = 1'b0;
  int          uart_cnt   = 0;
  logic        spur_idle  = 1'b0;
  logic        spur_fetch = 1'b0;
  bit          spur_fetch_en = 1'b0;

  logic [7:0] exp_q [$];
  logic [7:0] log_q [$];
  logic [7:0] exp_csum;
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // Synchronous read ports with one cycle of latency
  always @(posedge clk) begin
    reg_q      <= regs[bus.reg_addr];
    reg_addr_q <= bus.reg_addr;
    mem_q      <= mems[bus.mem_addr];
    mem_addr_q <= bus.mem_addr;
  end
  assign bus.reg_data = (bus.reg_addr == reg_addr_q) ? reg_q : POISON;
  assign bus.mem_data = (bus.mem_addr == mem_addr_q) ? mem_q : POISON;

  // UART model: done tick about 10 cycles after each tx_start
  always @(posedge clk) begin
    uart_tick <= 1'b0;
    if (bus.tx_start) begin
      uart_cnt <= 10;
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_tick <= 1'b1;
    end
  end
  assign bus.tx_done_tick = uart_tick | spur_idle | spur_fetch;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(w[8*b +: 8]);
`ifdef DEBUG_TX_CHECKSUM_EN
      exp_csum = exp_csum ^ w[8*b +: 8];
`endif
    end
  endtask

  task automatic push_frame(input logic [31:0] pc, input logic [31:0] cyc);
    exp_csum = 8'h00;
    exp_q.push_back(8'hA5);
    push_word(pc);
    push_word(cyc);
    for (int i = 0; i < 32; i++) push_word(regs[i]);
    for (int j = 0; j < 16; j++) push_word(mems[j]);
`ifdef DEBUG_TX_CHECKSUM_EN
    exp_q.push_back(exp_csum);
`endif
  endtask

  task automatic start_frame(input logic [31:0] pc, input logic [31:0] cyc);
    log_q.delete();
    push_frame(pc, cyc);
    @(negedge clk);
    bus.pc_in = pc;
    bus.cycles_in = cyc;
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    bus.pc_in = ~pc;
    bus.cycles_in = ~cyc;
  endtask

  task automatic wait_frame(input string tag);
    int t = 0;
    while (!bus.dump_done && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_dump_done"}, {31'd0, bus.dump_done}, 32'd1);
    chk({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_length"}, log_q.size(), FRAME_LEN);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  // Monitor: compare every transmitted byte against the scoreboard and count dump_done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (bus.dump_done) n_done++;
      if (bus.tx_start) begin
        log_q.push_back(bus.tx_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got %02h, expected no byte", bus.tx_data);
        end else begin
          chk($sformatf("byte%0d", log_q.size() - 1), {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Register addresses must advance by one; a tick is injected in each fetch cycle when enabled
  initial begin
    logic [4:0] rp;
    logic [3:0] mp;
    rp = 5'd0;
    mp = 4'd0;
    forever begin
      @(negedge clk);
      spur_fetch = spur_fetch_en && bus.busy && ((bus.reg_addr != rp) || (bus.mem_addr != mp));
      if (!reset && (bus.reg_addr != rp)) chk("reg_addr_step", {27'd0, bus.reg_addr}, {27'd0, 5'(rp + 5'd1)});
      rp = bus.reg_addr;
      mp = bus.mem_addr;
    end
  end

  initial begin
    logic [7:0] hdr [17];
    int t;
    hdr = '{8'hA5, 8'h10, 8'h00, 8'h40, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    bus.dump_req  = 1'b0;
    bus.pc_in     = 32'd0;
    bus.cycles_in = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    for (int j = 0; j < 16; j++) mems[j] = 32'h100 + 32'(j);

    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_dump_done", {31'd0, bus.dump_done}, 32'd0);
    chk("rst_reg_addr", {27'd0, bus.reg_addr}, 32'd0);
    chk("rst_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
    reset = 1'b0;

    // Spurious tick while idle must not start anything
    @(negedge clk);
    spur_idle = 1'b1;
    @(negedge clk);
    spur_idle = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tick_busy", {31'd0, bus.busy}, 32'd0);

    // Frame A: reference data with ticks injected during every fetch
    n_done = 0;
    spur_fetch_en = 1'b1;
    start_frame(32'h0040_0010, 32'h0000_002A);
    wait_frame("frameA");
    spur_fetch_en = 1'b0;
    if (log_q.size() >= 17) begin
      for (int i = 0; i < 17; i++) chk($sformatf("hdr%0d", i), {24'd0, log_q[i]}, {24'd0, hdr[i]});
    end else begin
      chk("hdr_length", log_q.size(), 32'd17);
    end
    repeat (20) @(negedge clk);
    chk("frameA_done_pulses", n_done, 32'd1);

    // Frame B: dump_req re-pulsed at byte 50 is ignored
    n_done = 0;
    start_frame(32'h0040_0010, 32'h0000_002A);
    t = 0;
    while (log_q.size() < 50 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frameB_reached_50", {31'd0, log_q.size() >= 50}, 32'd1);
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    wait_frame("frameB");
    repeat (20) @(negedge clk);
    chk("frameB_done_pulses", n_done, 32'd1);

    // Frame C: reset while waiting on byte 100, then frame D restarts cleanly
    start_frame(32'h1122_3344, 32'h5566_7788);
    t = 0;
    while (log_q.size() < 100 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frameC_reached_100", {31'd0, log_q.size() >= 100}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_tx_start", {31'd0, bus.tx_start}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (15) @(negedge clk);
    n_done = 0;
    start_frame(32'hCAFE_F00D, 32'h0000_0101);
    wait_frame("frameD");
    if (log_q.size() > 0) chk("frameD_first", {24'd0, log_q[0]}, 32'h0000_00A5);
    else chk("frameD_nonempty", log_q.size(), FRAME_LEN);

    // Frame E: all-zero storage, PC 01020304; checksum build ends on 0x04
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int j = 0; j < 16; j++) mems[j] = 32'd0;
    start_frame(32'h0102_0304, 32'h0000_0000);
    wait_frame("frameE");
    if (log_q.size() > 0) chk("frameE_last", {24'd0, log_q[log_q.size()-1]}, {24'd0, LAST_EXP});
    else chk("frameE_nonempty", log_q.size(), FRAME_LEN);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
